// File: rtl/progmem_access_ctrl.sv
// Program-memory port sequencer/arbiter: SPM > LPM > fetch; reads valid 3 cycles after grant sample.
// Losing requesters stay pending; all reads stall while an erase/program waits on mem_rdy.
module progmem_access_ctrl #(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [15:0]       if_data,
  input  logic              lpm_req,
  input  logic [ADDR_W:0]   lpm_zaddr,
  output logic              lpm_valid,
  output logic [7:0]        lpm_data,
  input  logic              spm_req,
  input  logic [1:0]        spm_op,
  input  logic [ADDR_W-1:0] spm_addr,
  input  logic [15:0]       spm_wdata,
  output logic              spm_done,
  output logic              spm_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [15:0]       mem_wdata,
  output logic              mem_erase,
  output logic              mem_prog,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rdy
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, SPM_BUSY} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

  state_t            state_q;
  logic              rd_ph_q;
  logic              rd_lpm_q;
  logic              lpm_hi_q;
  logic              resp_q;
  logic              resp_err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              if_valid_q;
  logic [15:0]       if_data_q;
  logic              lpm_valid_q;
  logic [7:0]        lpm_data_q;
  logic              spm_done_q;
  logic              spm_err_q;
  logic              busy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [15:0]       mem_wdata_q;
  logic              mem_erase_q;
  logic              mem_prog_q;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_ph_q     <= 1'b0;
      rd_lpm_q    <= 1'b0;
      lpm_hi_q    <= 1'b0;
      resp_q      <= 1'b0;
      resp_err_q  <= 1'b0;
      cnt_q       <= '0;
      if_valid_q  <= 1'b0;
      if_data_q   <= '0;
      lpm_valid_q <= 1'b0;
      lpm_data_q  <= '0;
      spm_done_q  <= 1'b0;
      spm_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_erase_q <= 1'b0;
      mem_prog_q  <= 1'b0;
    end else begin
      // Strobes and completion flags are single-cycle pulses.
      if_valid_q  <= 1'b0;
      lpm_valid_q <= 1'b0;
      spm_done_q  <= 1'b0;
      spm_err_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_erase_q <= 1'b0;
      mem_prog_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          // A buffer load or reserved op answers here, one cycle after grant,
          // without arbitrating so the held spm_req is not granted twice.
          if (resp_q) begin
            spm_done_q <= ~resp_err_q;
            spm_err_q  <= resp_err_q;
            resp_q     <= 1'b0;
          end else if (spm_req) begin
            case (spm_op)
              2'b00: begin
                mem_wr_q    <= 1'b1;
                mem_addr_q  <= spm_addr;
                mem_wdata_q <= spm_wdata;
                resp_q      <= 1'b1;
                resp_err_q  <= 1'b0;
              end
              2'b01, 2'b10: begin
                mem_erase_q <= (spm_op == 2'b01);
                mem_prog_q  <= (spm_op == 2'b10);
                mem_addr_q  <= spm_addr;
                busy_q      <= 1'b1;
                cnt_q       <= '0;
                state_q     <= SPM_BUSY;
              end
              default: begin
                resp_q     <= 1'b1;
                resp_err_q <= 1'b1;
              end
            endcase
          end else if (lpm_req) begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= lpm_zaddr[ADDR_W:1];
            rd_lpm_q   <= 1'b1;
            lpm_hi_q   <= lpm_zaddr[0];
            rd_ph_q    <= 1'b0;
            state_q    <= RD_WAIT;
          end else if (if_req) begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= if_addr;
            rd_lpm_q   <= 1'b0;
            rd_ph_q    <= 1'b0;
            state_q    <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          // First cycle is the array access; mem_rdata is on the bus in the second.
          if (!rd_ph_q) begin
            rd_ph_q <= 1'b1;
          end else begin
            if (rd_lpm_q) begin
              lpm_valid_q <= 1'b1;
              lpm_data_q  <= lpm_hi_q ? mem_rdata[15:8] : mem_rdata[7:0];
            end else begin
              if_valid_q <= 1'b1;
              if_data_q  <= mem_rdata;
            end
            state_q <= IDLE;
          end
        end

        SPM_BUSY: begin
          cnt_q <= cnt_d;
          // mem_rdy seen with the counter still at 0 predates the array reacting to the strobe.
          if ((cnt_q != '0) && mem_rdy) begin
            spm_done_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else if (cnt_q >= TMO) begin
            spm_err_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_valid  = if_valid_q;
  assign if_data   = if_data_q;
  assign lpm_valid = lpm_valid_q;
  assign lpm_data  = lpm_data_q;
  assign spm_done  = spm_done_q;
  assign spm_err   = spm_err_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_erase = mem_erase_q;
  assign mem_prog  = mem_prog_q;

endmodule

// File: tb/tb_progmem_access_ctrl.sv
// Directed bench for progmem_access_ctrl with a registered program-memory model.
module tb_progmem_access_ctrl;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_valid;
  logic [15:0]   if_data;
  logic          lpm_req = 1'b0;
  logic [AW:0]   lpm_zaddr = '0;
  logic          lpm_valid;
  logic [7:0]    lpm_data;
  logic          spm_req = 1'b0;
  logic [1:0]    spm_op = 2'b00;
  logic [AW-1:0] spm_addr = '0;
  logic [15:0]   spm_wdata = '0;
  logic          spm_done;
  logic          spm_err;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [15:0]   mem_wdata;
  logic          mem_erase;
  logic          mem_prog;
  logic [15:0]   mem_rdata = '0;
  logic          mem_rdy = 1'b1;

  progmem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
    .lpm_req(lpm_req), .lpm_zaddr(lpm_zaddr), .lpm_valid(lpm_valid), .lpm_data(lpm_data),
    .spm_req(spm_req), .spm_op(spm_op), .spm_addr(spm_addr), .spm_wdata(spm_wdata),
    .spm_done(spm_done), .spm_err(spm_err), .busy(busy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_erase(mem_erase), .mem_prog(mem_prog), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  int rd_cnt = 0, wr_cnt = 0, er_cnt = 0, pg_cnt = 0;
  int ifv_cnt = 0, lpv_cnt = 0, multi_cnt = 0, b2b_cnt = 0;
  logic prev_rd = 1'b0;
  always @(posedge clk) begin
    rd_cnt  <= rd_cnt + int'(mem_rd);
    wr_cnt  <= wr_cnt + int'(mem_wr);
    er_cnt  <= er_cnt + int'(mem_erase);
    pg_cnt  <= pg_cnt + int'(mem_prog);
    ifv_cnt <= ifv_cnt + int'(if_valid);
    lpv_cnt <= lpv_cnt + int'(lpm_valid);
    if ((int'(mem_rd) + int'(mem_wr) + int'(mem_erase) + int'(mem_prog)) > 1) multi_cnt <= multi_cnt + 1;
    if (prev_rd && mem_rd) b2b_cnt <= b2b_cnt + 1;
    prev_rd <= mem_rd;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Single uncontended read; the requester changes its address right after grant.
  task automatic do_read(input bit lpm, input logic [AW:0] a, input logic [15:0] exp, input string tag);
    @(negedge clk);
    if (lpm) begin lpm_req = 1'b1; lpm_zaddr = a; end
    else begin if_req = 1'b1; if_addr = a[AW-1:0]; end
    @(negedge clk);
    check({tag, "_rd"}, 64'(mem_rd), 64'd1);
    check({tag, "_addr"}, 64'(mem_addr), lpm ? 64'(a[AW:1]) : 64'(a[AW-1:0]));
    lpm_zaddr = ~a;
    if_addr = ~a[AW-1:0];
    @(negedge clk);
    check({tag, "_rd_once"}, 64'({mem_rd, if_valid, lpm_valid}), 64'd0);
    @(negedge clk);
    if (lpm) begin
      check({tag, "_valid"}, 64'({lpm_valid, if_valid}), 64'b10);
      check({tag, "_data"}, 64'(lpm_data), 64'(exp[7:0]));
      lpm_req = 1'b0;
    end else begin
      check({tag, "_valid"}, 64'({if_valid, lpm_valid}), 64'b10);
      check({tag, "_data"}, 64'(if_data), 64'(exp));
      if_req = 1'b0;
    end
    @(negedge clk);
    check({tag, "_pulse"}, 64'({if_valid, lpm_valid}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0, i0, l0, p0, e0, w0;

    mem[14'h0123] = 16'h940C;
    mem[14'h0180] = 16'h2233;
    mem[14'h0200] = 16'h1111;

    // Reset with every requester asserting.
    if_req = 1'b1; if_addr = 14'h0200;
    lpm_req = 1'b1; lpm_zaddr = 15'h0301;
    spm_req = 1'b1; spm_op = 2'b00; spm_addr = 14'h0010; spm_wdata = 16'hBEEF;
    repeat (3) @(negedge clk);
    check("rst_outputs", {1'b0, if_valid, if_data, lpm_valid, lpm_data, spm_done, spm_err, busy,
                          mem_addr, mem_rd, mem_wr, mem_wdata, mem_erase, mem_prog}, 64'd0);
    check("rst_no_strobe", 64'(rd_cnt + wr_cnt + er_cnt + pg_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_grant", 64'({mem_wr, mem_rd}), 64'b10);
    check("rst_wr_addr", 64'(mem_addr), 64'h0010);
    check("rst_wr_data", 64'(mem_wdata), 64'hBEEF);
    if_req = 1'b0; lpm_req = 1'b0;
    @(negedge clk);
    check("ld_done", 64'({spm_done, spm_err, mem_wr}), 64'b100);
    spm_req = 1'b0;
    @(negedge clk);
    check("ld_single", 64'({spm_done, mem_rd}), 64'd0);
    check("ld_wr_count", 64'(wr_cnt), 64'd1);

    // Fetch, then LPM high and low byte.
    do_read(1'b0, 15'h0123, 16'h940C, "fetch");
    mem[14'h0123] = 16'hA55A;
    do_read(1'b1, 15'h0247, 16'h00A5, "lpm_hi");
    do_read(1'b1, 15'h0246, 16'h005A, "lpm_lo");

    // LPM and fetch together: LPM first, fetch afterwards.
    @(negedge clk);
    i0 = ifv_cnt; l0 = lpv_cnt;
    if_req = 1'b1; if_addr = 14'h0200;
    lpm_req = 1'b1; lpm_zaddr = 15'h0301;
    @(negedge clk);
    check("both_lpm_addr", 64'({mem_rd, mem_addr}), {49'd0, 1'b1, 14'h0180});
    repeat (2) @(negedge clk);
    check("both_lpm_valid", 64'({lpm_valid, if_valid}), 64'b10);
    check("both_lpm_data", 64'(lpm_data), 64'h22);
    lpm_req = 1'b0;
    @(negedge clk);
    check("both_if_addr", 64'({mem_rd, mem_addr}), {49'd0, 1'b1, 14'h0200});
    repeat (2) @(negedge clk);
    check("both_if_valid", 64'({if_valid, lpm_valid}), 64'b10);
    check("both_if_data", 64'(if_data), 64'h1111);
    if_req = 1'b0;
    @(negedge clk);
    check("both_if_count", 64'(ifv_cnt - i0), 64'd1);
    check("both_lpm_count", 64'(lpv_cnt - l0), 64'd1);

    // Page write with a slow array; a fetch waits it out.
    p0 = pg_cnt;
    spm_req = 1'b1; spm_op = 2'b10; spm_addr = 14'h0040; mem_rdy = 1'b1;
    @(negedge clk);
    check("prog_strobe", 64'({mem_prog, mem_erase, mem_wr, mem_rd, busy}), 64'b10001);
    check("prog_addr", 64'(mem_addr), 64'h0040);
    if_req = 1'b1; if_addr = 14'h0200;
    @(negedge clk);
    check("prog_rdy_ignored", 64'({busy, spm_done}), 64'b10);
    mem_rdy = 1'b0;
    r0 = rd_cnt; i0 = ifv_cnt;
    repeat (50) @(negedge clk);
    check("prog_stall", 64'({rd_cnt - r0, ifv_cnt - i0}), 64'd0);
    check("prog_busy", 64'({busy, spm_done, spm_err}), 64'b100);
    mem_rdy = 1'b1;
    @(negedge clk);
    check("prog_done", 64'({spm_done, spm_err, busy}), 64'b100);
    check("prog_count", 64'(pg_cnt - p0), 64'd1);
    spm_req = 1'b0;
    n = 0;
    while (!if_valid && n < 20) begin @(negedge clk); n++; end
    check("prog_fetch_lat", 64'(n), 64'd3);
    check("prog_fetch_data", 64'(if_data), 64'h1111);
    if_req = 1'b0;

    // Reserved op: error without any strobe.
    @(negedge clk);
    r0 = rd_cnt; w0 = wr_cnt; e0 = er_cnt; p0 = pg_cnt;
    spm_req = 1'b1; spm_op = 2'b11;
    @(negedge clk);
    check("rsv_no_strobe", 64'({mem_rd, mem_wr, mem_erase, mem_prog, spm_err, busy}), 64'd0);
    @(negedge clk);
    check("rsv_err", 64'({spm_err, spm_done}), 64'b10);
    spm_req = 1'b0;
    @(negedge clk);
    check("rsv_counts", 64'((rd_cnt - r0) + (wr_cnt - w0) + (er_cnt - e0) + (pg_cnt - p0)), 64'd0);

    // Erase with mem_rdy stuck low: timeout error.
    e0 = er_cnt;
    spm_req = 1'b1; spm_op = 2'b01; spm_addr = 14'h0080; mem_rdy = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("tmo_strobe", 64'({mem_erase, mem_prog, busy}), 64'b101);
    end while (!spm_err && n < 5000);
    check("tmo_cycle", 64'(n), 64'd4098);
    check("tmo_flags", 64'({spm_err, spm_done, busy}), 64'b100);
    spm_req = 1'b0; mem_rdy = 1'b1;
    @(negedge clk);
    check("tmo_erase_count", 64'(er_cnt - e0), 64'd1);
    check("tmo_pulse", 64'({spm_err, busy}), 64'd0);

    check("strobe_onehot", 64'(multi_cnt), 64'd0);
    check("rd_back_to_back", 64'(b2b_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
